// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-pin direction, atomic set/clear, synchronised and
// debounced inputs, rise/fall edge capture into W1C STATUS with a level interrupt.
module gpio_bank #(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] pins_oe,
    output logic             irq_out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        REG_OUT     = 3'd0,
        REG_DIR     = 3'd1,
        REG_IN      = 3'd2,
        REG_RISE_EN = 3'd3,
        REG_FALL_EN = 3'd4,
        REG_STATUS  = 3'd5,
        REG_SET     = 3'd6,
        REG_CLR     = 3'd7
    } reg_e;

    reg_e             reg_sel;
    logic             wr_en;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask, wbits;

    logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s, prev_q, level_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic             tick, primed_q;
    logic [WIDTH-1:0] change, rise, fall, status_set, status_clr;
    logic [31:0]      rdata;
    logic             unused_bus;

    assign reg_sel   = reg_e'(address_in[4:2]);
    assign wr_en     = sel_in && (write_mask_in != 4'b0000);
    assign lane_mask = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                        {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
    assign wmask     = lane_mask[WIDTH-1:0];
    assign wbits     = write_value_in[WIDTH-1:0] & wmask;
    assign unused_bus = &{1'b0, read_in, address_in[31:5], address_in[1:0],
                          write_value_in, lane_mask};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q     <= RESET_OUT;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr_en) begin
            unique case (reg_sel)
                REG_OUT:     out_q     <= (out_q & ~wmask) | wbits;
                REG_DIR:     dir_q     <= (dir_q & ~wmask) | wbits;
                REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wbits;
                REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wbits;
                REG_SET:     out_q     <= out_q | wbits;
                REG_CLR:     out_q     <= out_q & ~wbits;
                default: ;
            endcase
        end
    end

    // NOTE: the synchroniser array is a bank of flops, not a RAM, so each entry is
    // reset explicitly; pad values must not leak through before the first tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pins_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            prev_q     <= '0;
            level_q    <= '0;
            primed_q   <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) begin
                prev_q <= s;
                if (!primed_q) begin
                    level_q  <= s;
                    primed_q <= 1'b1;
                end else begin
                    level_q <= level_q ^ change;
                end
            end
        end
    end

    // A pin moves only when two consecutive ticks agree on a value that differs from IN.
    assign change     = (tick && primed_q) ? (~(s ^ prev_q) & (s ^ level_q)) : '0;
    assign rise       = change & s;
    assign fall       = change & ~s;
    assign status_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign status_clr = (wr_en && reg_sel == REG_STATUS) ? wbits : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) status_q <= '0;
        else        status_q <= (status_q & ~status_clr) | status_set;
    end

    // NOTE: rdata gets a default before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_OUT:     rdata[WIDTH-1:0] = out_q;
            REG_DIR:     rdata[WIDTH-1:0] = dir_q;
            REG_IN:      rdata[WIDTH-1:0] = level_q;
            REG_RISE_EN: rdata[WIDTH-1:0] = rise_en_q;
            REG_FALL_EN: rdata[WIDTH-1:0] = fall_en_q;
            REG_STATUS:  rdata[WIDTH-1:0] = status_q;
            default: ;
        endcase
    end

    assign read_value_out = sel_in ? rdata : 32'h0;
    assign ready_out      = sel_in;
    assign pins_out       = out_q;
    assign pins_oe        = dir_q;
    assign irq_out        = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: constant vector table, hand-timed corner cases,
// and a randomized phase scored against a pin-history model of the register map.
module tb_gpio_bank;

    localparam int W = 8;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic        sel = 1'b0, sel2 = 1'b0, read = 1'b0;
    logic [3:0]  mask = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, rdata2;
    logic        ready, ready2, irq, irq2;
    logic [7:0]  pins = 8'hFF, pins2 = 8'h00;
    logic [7:0]  pins_out, pins_oe, pins2_out, pins2_oe;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_OUT(8'h00)) dut (
        .clk(clk), .reset(reset), .address_in(address), .sel_in(sel), .read_in(read),
        .read_value_out(rdata), .write_mask_in(mask), .write_value_in(wdata),
        .ready_out(ready), .pins_in(pins), .pins_out(pins_out), .pins_oe(pins_oe),
        .irq_out(irq));

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_OUT(8'h3C)) dut_db (
        .clk(clk), .reset(reset), .address_in(address), .sel_in(sel2), .read_in(read),
        .read_value_out(rdata2), .write_mask_in(mask), .write_value_in(wdata),
        .ready_out(ready2), .pins_in(pins2), .pins_out(pins2_out), .pins_oe(pins2_oe),
        .irq_out(irq2));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model for dut: registers plus the full history of sampled pad values.
    logic [7:0] m_out = '0, m_dir = '0, m_rise = '0, m_fall = '0, m_status = '0, m_level = '0;
    logic [7:0] hist[$];
    int         k = 0;

    function automatic logic [7:0] p_at(input int j);
        return (j < 1) ? 8'h00 : hist[j-1];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[4:2])
            3'd0: return {24'h0, m_out};
            3'd1: return {24'h0, m_dir};
            3'd2: return {24'h0, m_level};
            3'd3: return {24'h0, m_rise};
            3'd4: return {24'h0, m_fall};
            3'd5: return {24'h0, m_status};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [7:0] s_now, s_old, rs, fl, lm, wd, clr, set_bits;
        if (!reset) begin
            m_out = 8'h00; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0; m_level = '0;
            hist.delete();
            k = 0;
        end else begin
            k++;
            hist.push_back(pins);
            // The value seen by the debouncer at edge k was sampled S edges earlier.
            s_now = p_at(k - S);
            s_old = p_at(k - 1 - S);
            rs = '0; fl = '0;
            if (k == 1) m_level = s_now;
            else begin
                for (int i = 0; i < W; i++) begin
                    if (s_now[i] == s_old[i] && s_now[i] != m_level[i]) begin
                        m_level[i] = s_now[i];
                        if (s_now[i]) rs[i] = 1'b1;
                        else          fl[i] = 1'b1;
                    end
                end
            end
            set_bits = (rs & m_rise) | (fl & m_fall);
            clr = '0;
            if (sel && mask != 4'h0) begin
                lm = {8{mask[0]}};
                wd = wdata[7:0] & lm;
                case (address[4:2])
                    3'd0: m_out  = (m_out & ~lm) | wd;
                    3'd1: m_dir  = (m_dir & ~lm) | wd;
                    3'd3: m_rise = (m_rise & ~lm) | wd;
                    3'd4: m_fall = (m_fall & ~lm) | wd;
                    3'd5: clr    = wd;
                    3'd6: m_out  = m_out | wd;
                    3'd7: m_out  = m_out & ~wd;
                    default: ;
                endcase
            end
            m_status = (m_status & ~clr) | set_bits;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_idle();
        sel = 1'b0; sel2 = 1'b0; read = 1'b0; mask = 4'h0;
    endtask

    task automatic write(input bit to_db, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d);
        sel = !to_db; sel2 = to_db; read = 1'b0; address = a; mask = m; wdata = d;
        tick();
        bus_idle();
    endtask

    task automatic read_chk(input bit to_db, input logic [31:0] a, input logic [31:0] exp,
                            input string name);
        sel = !to_db; sel2 = to_db; read = 1'b1; address = a; mask = 4'h0;
        #1;
        check(name, to_db ? rdata2 : rdata, exp);
        bus_idle();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [31:0] rd_addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h00, 4'hF, 32'h0000_000F, 32'h00, 32'h0F};
        vecs[1]  = '{32'h18, 4'hF, 32'h0000_00A0, 32'h00, 32'hAF};
        vecs[2]  = '{32'h1C, 4'hF, 32'h0000_0003, 32'h00, 32'hAC};
        vecs[3]  = '{32'h00, 4'h2, 32'h1234_5678, 32'h00, 32'hAC};
        vecs[4]  = '{32'h04, 4'h1, 32'hFFFF_FF5A, 32'h04, 32'h5A};
        vecs[5]  = '{32'h04, 4'hE, 32'hFFFF_FFFF, 32'h04, 32'h5A};
        vecs[6]  = '{32'h0C, 4'hF, 32'h0000_01FF, 32'h0C, 32'hFF};
        vecs[7]  = '{32'h08, 4'hF, 32'h0000_0000, 32'h08, 32'hFF};
        vecs[8]  = '{32'h18, 4'h1, 32'h0000_0000, 32'h18, 32'h00};
        vecs[9]  = '{32'h1C, 4'h1, 32'h0000_0000, 32'h1C, 32'h00};
        vecs[10] = '{32'h0C, 4'hF, 32'h0000_0000, 32'h0C, 32'h00};
        vecs[11] = '{32'h10, 4'hF, 32'hFFFF_FF00, 32'h10, 32'h00};

        // Reset with all pads high.
        ticks(3);
        check("rst_pins_out", 32'(pins_out), 32'h00);
        check("rst_pins_oe", 32'(pins_oe), 32'h00);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_db_pins_out", 32'(pins2_out), 32'h3C);
        reset = 1'b1;
        ticks(6);
        read_chk(0, 32'h00, 32'h00, "rst_out");
        check("rst_ready", 32'(ready), 32'h0);
        read_chk(0, 32'h04, 32'h00, "rst_dir");
        read_chk(0, 32'h08, 32'hFF, "rst_in_primed");
        read_chk(0, 32'h14, 32'h00, "rst_status");
        check("rst_irq_after", 32'(irq), 32'h0);

        // Register map vectors.
        for (int i = 0; i < 12; i++) begin
            write(0, vecs[i].addr, vecs[i].mask, vecs[i].data);
            read_chk(0, vecs[i].rd_addr, vecs[i].exp, $sformatf("vec%0d", i));
        end
        check("vec_pins_out", 32'(pins_out), 32'hAC);
        check("vec_pins_oe", 32'(pins_oe), 32'h5A);
        sel = 1'b1; read = 1'b1; address = 32'h0;
        #1;
        check("ready_sel", 32'(ready), 32'h1);
        bus_idle();

        // Rising-edge interrupt, E+3 latency.
        pins = 8'h00;
        ticks(5);
        read_chk(0, 32'h14, 32'h00, "rise_pre_status");
        write(0, 32'h0C, 4'hF, 32'h01);
        pins = 8'h01;
        tick();
        check("rise_e0_irq", 32'(irq), 32'h0);
        tick();
        check("rise_e1_irq", 32'(irq), 32'h0);
        tick();
        check("rise_e2_irq", 32'(irq), 32'h0);
        tick();
        read_chk(0, 32'h14, 32'h01, "rise_e3_status");
        check("rise_e3_irq", 32'(irq), 32'h1);
        write(0, 32'h14, 4'h1, 32'h01);
        check("rise_w1c_irq", 32'(irq), 32'h0);

        // Set wins over a simultaneous W1C.
        write(0, 32'h10, 4'hF, 32'h02);
        pins = 8'h03;
        ticks(5);
        check("race_pre_irq", 32'(irq), 32'h0);
        pins = 8'h01;
        ticks(5);
        read_chk(0, 32'h14, 32'h02, "race_fall_status");
        pins = 8'h03;
        ticks(5);
        pins = 8'h01;
        ticks(3);
        write(0, 32'h14, 4'h1, 32'h02);
        read_chk(0, 32'h14, 32'h02, "race_set_wins");
        check("race_irq_held", 32'(irq), 32'h1);
        write(0, 32'h14, 4'h1, 32'h02);
        check("race_cleared_irq", 32'(irq), 32'h0);

        // Debounce on the 4-cycle instance.
        write(1, 32'h0C, 4'hF, 32'h04);
        pins2 = 8'h04;
        ticks(3);
        pins2 = 8'h00;
        ticks(12);
        read_chk(1, 32'h08, 32'h00, "db_pulse_in");
        read_chk(1, 32'h14, 32'h00, "db_pulse_status");
        check("db_pulse_irq", 32'(irq2), 32'h0);
        pins2 = 8'h04;
        ticks(12);
        read_chk(1, 32'h08, 32'h04, "db_hold_in");
        read_chk(1, 32'h14, 32'h04, "db_hold_status");
        check("db_hold_irq", 32'(irq2), 32'h1);
        check("db_pins_out", 32'(pins2_out), 32'h3C);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [31:0] idx;
            bus_idle();
            r = $urandom_range(0, 9);
            idx = 32'($urandom_range(0, 7));
            if (r < 4) begin
                sel = 1'b1;
                address = ($urandom() & 32'hFFFF_FFE3) | (idx << 2);
                mask = 4'($urandom_range(1, 15));
                wdata = $urandom();
            end else if (r < 8) begin
                sel = 1'b1;
                read = 1'b1;
                address = ($urandom() & 32'hFFFF_FFE3) | (idx << 2);
            end
            pins = pins ^ 8'($urandom() & $urandom() & $urandom());
            #1;
            if (read) check("rand_read", rdata, m_read(address));
            else if (!sel) check("rand_idle_read", rdata, 32'h0);
            check("rand_pins_out", 32'(pins_out), 32'(m_out));
            check("rand_pins_oe", 32'(pins_oe), 32'(m_dir));
            check("rand_irq", 32'(irq), 32'(m_status != 8'h00));
            tick();
        end
        bus_idle();

        // Asynchronous reset between clock edges.
        write(0, 32'h00, 4'hF, 32'h55);
        write(0, 32'h0C, 4'hF, 32'hFF);
        write(0, 32'h10, 4'hF, 32'hFF);
        pins = ~pins;
        ticks(5);
        check("pre_areset_irq", 32'(irq), 32'h1);
        check("pre_areset_out", 32'(pins_out), 32'h55);
        #2;
        reset = 1'b0;
        #1;
        check("areset_pins_out", 32'(pins_out), 32'h00);
        check("areset_irq", 32'(irq), 32'h0);
        check("areset_pins_oe", 32'(pins_oe), 32'h00);
        read_chk(0, 32'h14, 32'h00, "areset_status");
        check("areset_db_pins_out", 32'(pins2_out), 32'h3C);
        check("areset_db_irq", 32'(irq2), 32'h0);
        #1;
        reset = 1'b1;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
